// File: rtl/vrased_reset_ctrl.sv
// vrased_reset_ctrl
//   Collects the per-monitor violation lines into one registered, stretched CPU
//   reset request. The request is held until the core fetches RESET_HANDLER.
//   Optional cause logging is enabled by defining VRASED_CAUSE_LOG_EN. When it is
//   not defined, cause and rst_count read as zero and cause_clr has no effect.
module vrased_reset_ctrl #(
  parameter int          NUM_SRC       = 7,
  parameter int          HOLD_CYCLES   = 4,
  parameter int          WAIT_MAX      = 16,
  parameter logic [15:0] RESET_HANDLER = 16'h0000,
  parameter int          CNT_W         = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_SRC-1:0] viol,
  input  logic [15:0]        pc,
  input  logic               cause_clr,
  output logic               cpu_rst,
  output logic               busy,
  output logic               done,
  output logic [NUM_SRC-1:0] cause,
  output logic [CNT_W-1:0]   rst_count
);

  localparam int HOLD_W = $clog2(HOLD_CYCLES + 1);
  localparam int WAIT_W = $clog2(WAIT_MAX + 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(WAIT_MAX - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HOLD = 2'd1,
    ST_WAIT = 2'd2
  } state_t;

  state_t            state_reg;
  logic [HOLD_W-1:0] hold_cnt_reg;
  logic [WAIT_W-1:0] wait_cnt_reg;
  logic              any_viol;

  assign any_viol = |viol;

  // Recovery FSM: stretch the reset request, then wait for the core to reach the
  // reset vector; any violation (or a timeout) re-arms the hold phase.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg    <= ST_IDLE;
      hold_cnt_reg <= '0;
      wait_cnt_reg <= '0;
      cpu_rst      <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          if (any_viol) begin
            state_reg    <= ST_HOLD;
            hold_cnt_reg <= '0;
            cpu_rst      <= 1'b1;
            busy         <= 1'b1;
          end
        end
        ST_HOLD: begin
          if (any_viol) begin
            // Retrigger: the high-time is always measured from the last violation.
            hold_cnt_reg <= '0;
          end else if (hold_cnt_reg == HOLD_LAST) begin
            state_reg    <= ST_WAIT;
            wait_cnt_reg <= '0;
            cpu_rst      <= 1'b0;
          end else begin
            hold_cnt_reg <= hold_cnt_reg + HOLD_W'(1);
          end
        end
        ST_WAIT: begin
          // Priority: new violation, then successful fetch of the vector, then timeout.
          if (any_viol) begin
            state_reg    <= ST_HOLD;
            hold_cnt_reg <= '0;
            cpu_rst      <= 1'b1;
          end else if (pc == RESET_HANDLER) begin
            state_reg <= ST_IDLE;
            busy      <= 1'b0;
            done      <= 1'b1;
          end else if (wait_cnt_reg == WAIT_LAST) begin
            state_reg    <= ST_HOLD;
            hold_cnt_reg <= '0;
            cpu_rst      <= 1'b1;
          end else begin
            wait_cnt_reg <= wait_cnt_reg + WAIT_W'(1);
          end
        end
        default: begin
          state_reg <= ST_IDLE;
          cpu_rst   <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

`ifdef VRASED_CAUSE_LOG_EN
  logic [NUM_SRC-1:0] cause_reg;
  logic [CNT_W-1:0]   rst_count_reg;

  // Sticky cause log and saturating count of fresh reset events (IDLE exits only).
  always_ff @(posedge clk) begin
    if (reset) begin
      cause_reg     <= '0;
      rst_count_reg <= '0;
    end else begin
      // A clear in the same cycle as a violation keeps that violation.
      if ((state_reg == ST_IDLE) && cause_clr) begin
        cause_reg <= viol;
      end else begin
        cause_reg <= cause_reg | viol;
      end
      if ((state_reg == ST_IDLE) && any_viol && (rst_count_reg != '1)) begin
        rst_count_reg <= rst_count_reg + CNT_W'(1);
      end
    end
  end

  assign cause     = cause_reg;
  assign rst_count = rst_count_reg;
`else
  logic unused_cause_clr;

  assign unused_cause_clr = cause_clr;
  assign cause            = '0;
  assign rst_count        = '0;
`endif

endmodule

// File: tb/tb_vrased_reset_ctrl.sv
// tb_vrased_reset_ctrl
//   Directed scenarios followed by randomized traffic. Each cycle is compared
//   against a countdown-style behavioural model of the recovery sequence.
module tb_vrased_reset_ctrl;

  localparam int          NUM_SRC     = 7;
  localparam int          HOLD_CYCLES = 4;
  localparam int          WAIT_MAX    = 16;
  localparam logic [15:0] RH          = 16'h0000;
  localparam int          CNT_W       = 8;
  localparam int          CNT_MAX     = 255;

  logic               clk = 1'b0;
  logic               reset;
  logic [NUM_SRC-1:0] viol;
  logic [15:0]        pc;
  logic               cause_clr;
  logic               cpu_rst;
  logic               busy;
  logic               done;
  logic [NUM_SRC-1:0] cause;
  logic [CNT_W-1:0]   rst_count;

  always #5 clk = ~clk;

  vrased_reset_ctrl #(
    .NUM_SRC(NUM_SRC), .HOLD_CYCLES(HOLD_CYCLES), .WAIT_MAX(WAIT_MAX),
    .RESET_HANDLER(RH), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .reset(reset), .viol(viol), .pc(pc), .cause_clr(cause_clr),
    .cpu_rst(cpu_rst), .busy(busy), .done(done), .cause(cause), .rst_count(rst_count)
  );

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // Behavioural model: remaining high cycles, elapsed wait time, event tally.
  bit               m_idle = 1'b1;
  int               m_hold_left = 0;
  int               m_wait_elapsed = 0;
  int               m_events = 0;
  logic [NUM_SRC-1:0] m_cause = '0;
  bit               m_done = 1'b0;

  int high_cnt = 0;
  int done_cnt = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic model_step();
    bit any;
    any = |viol;
    if (reset) begin
      m_idle = 1'b1; m_hold_left = 0; m_wait_elapsed = 0;
      m_events = 0; m_cause = '0; m_done = 1'b0;
    end else begin
      m_done = 1'b0;
      if (m_idle && cause_clr) m_cause = viol;
      else                     m_cause = m_cause | viol;
      if (m_idle) begin
        if (any) begin
          m_idle = 1'b0;
          m_hold_left = HOLD_CYCLES;
          if (m_events < CNT_MAX) m_events++;
        end
      end else if (m_hold_left > 0) begin
        if (any) m_hold_left = HOLD_CYCLES;
        else begin
          m_hold_left--;
          if (m_hold_left == 0) m_wait_elapsed = 0;
        end
      end else begin
        if (any) m_hold_left = HOLD_CYCLES;
        else if (pc == RH) begin
          m_idle = 1'b1;
          m_done = 1'b1;
        end else begin
          m_wait_elapsed++;
          if (m_wait_elapsed == WAIT_MAX) m_hold_left = HOLD_CYCLES;
        end
      end
    end
  endtask

  task automatic cycle(input logic [NUM_SRC-1:0] v, input logic [15:0] p,
                       input logic clr, input logic rst);
    logic [NUM_SRC-1:0] exp_cause;
    int                 exp_cnt;
    viol = v; pc = p; cause_clr = clr; reset = rst;
    @(posedge clk);
    model_step();
    #1;
    cyc++;
`ifdef VRASED_CAUSE_LOG_EN
    exp_cause = m_cause;
    exp_cnt   = m_events;
`else
    exp_cause = '0;
    exp_cnt   = 0;
`endif
    $display("cyc %0d viol=%02h pc=%04h clr=%0b rst=%0b | cpu_rst=%0b busy=%0b done=%0b cause=%02h cnt=%0d",
             cyc, v, p, clr, rst, cpu_rst, busy, done, cause, rst_count);
    chk("cpu_rst", 32'(cpu_rst), 32'(!m_idle && m_hold_left > 0));
    chk("busy", 32'(busy), 32'(!m_idle));
    chk("done", 32'(done), 32'(m_done));
    chk("cause", 32'(cause), 32'(exp_cause));
    chk("rst_count", 32'(rst_count), 32'(exp_cnt));
    if (cpu_rst === 1'b1) high_cnt++;
    if (done === 1'b1) done_cnt++;
  endtask

  localparam logic [15:0] PC_RUN = 16'h1234;

  initial begin
    logic [NUM_SRC-1:0] rv;
    logic [15:0]        rp;
    viol = '0; pc = PC_RUN; cause_clr = 1'b0; reset = 1'b1;

    // Test 1: reset with every violation line asserted.
    cycle(7'h7F, PC_RUN, 1'b0, 1'b1);
    cycle(7'h7F, PC_RUN, 1'b0, 1'b1);
    chk("t1_cpu_rst", 32'(cpu_rst), 32'd0);
    chk("t1_busy", 32'(busy), 32'd0);

    // Test 2: single-cycle violation, then recovery via the reset vector.
    high_cnt = 0; done_cnt = 0;
    cycle(7'h02, PC_RUN, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) cycle(7'h00, PC_RUN, 1'b0, 1'b0);
    cycle(7'h00, RH, 1'b0, 1'b0);
    cycle(7'h00, PC_RUN, 1'b0, 1'b0);
    chk("t2_high_cycles", 32'(high_cnt), 32'd4);
    chk("t2_done_pulses", 32'(done_cnt), 32'd1);
`ifdef VRASED_CAUSE_LOG_EN
    chk("t2_cause", 32'(cause), 32'h02);
    chk("t2_count", 32'(rst_count), 32'd1);
`else
    chk("t2_cause", 32'(cause), 32'h00);
    chk("t2_count", 32'(rst_count), 32'd0);
`endif

    // Test 3: retrigger on the third hold cycle stretches the request to 7 cycles.
    cycle(7'h00, PC_RUN, 1'b0, 1'b1);
    cycle(7'h00, PC_RUN, 1'b0, 1'b1);
    high_cnt = 0;
    cycle(7'h01, PC_RUN, 1'b0, 1'b0);
    cycle(7'h00, PC_RUN, 1'b0, 1'b0);
    cycle(7'h00, PC_RUN, 1'b0, 1'b0);
    cycle(7'h40, PC_RUN, 1'b0, 1'b0);
    for (int i = 0; i < 6; i++) cycle(7'h00, PC_RUN, 1'b0, 1'b0);
    chk("t3_high_cycles", 32'(high_cnt), 32'd7);
    cycle(7'h00, RH, 1'b0, 1'b0);
    chk("t3_idle", 32'(busy), 32'd0);
`ifdef VRASED_CAUSE_LOG_EN
    chk("t3_cause", 32'(cause), 32'h41);
    chk("t3_count", 32'(rst_count), 32'd1);
`endif

    // Test 4: core never reaches the vector -> timeout re-asserts the request.
    cycle(7'h00, PC_RUN, 1'b0, 1'b1);
    cycle(7'h00, PC_RUN, 1'b0, 1'b1);
    cycle(7'h01, 16'hE000, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) cycle(7'h00, 16'hE000, 1'b0, 1'b0);
    high_cnt = 0;
    for (int i = 0; i < WAIT_MAX; i++) cycle(7'h00, 16'hE000, 1'b0, 1'b0);
    chk("t4_wait_low", 32'(high_cnt), 32'd0);
    for (int i = 0; i < HOLD_CYCLES; i++) cycle(7'h00, 16'hE000, 1'b0, 1'b0);
    chk("t4_rehold_cycles", 32'(high_cnt), 32'd4);
    cycle(7'h00, 16'hE000, 1'b0, 1'b0);
    chk("t4_release", 32'(cpu_rst), 32'd0);
    cycle(7'h00, RH, 1'b0, 1'b0);
`ifdef VRASED_CAUSE_LOG_EN
    chk("t4_count", 32'(rst_count), 32'd1);
`endif

    // Test 5: clear and violation in the same idle cycle, then count saturation.
    cycle(7'h10, PC_RUN, 1'b1, 1'b0);
    chk("t5_busy", 32'(busy), 32'd1);
`ifdef VRASED_CAUSE_LOG_EN
    chk("t5_cause", 32'(cause), 32'h10);
`endif
    for (int i = 0; i < 5; i++) cycle(7'h00, RH, 1'b0, 1'b0);
    for (int e = 0; e < 300; e++) begin
      rv = NUM_SRC'($urandom_range(1, 127));
      cycle(rv, RH, 1'b0, 1'b0);
      for (int i = 0; i < 5; i++) cycle(7'h00, RH, 1'b0, 1'b0);
    end
`ifdef VRASED_CAUSE_LOG_EN
    chk("t5_saturate", 32'(rst_count), 32'hFF);
`else
    chk("t5_saturate", 32'(rst_count), 32'h00);
`endif

    // Test 6: reset in the middle of a hold phase.
    cycle(7'h04, PC_RUN, 1'b0, 1'b0);
    cycle(7'h00, PC_RUN, 1'b0, 1'b0);
    cycle(7'h00, PC_RUN, 1'b0, 1'b1);
    chk("t6_cpu_rst", 32'(cpu_rst), 32'd0);
    chk("t6_busy", 32'(busy), 32'd0);
    chk("t6_cause", 32'(cause), 32'd0);

    // Randomized traffic against the model, with occasional resets.
    for (int i = 0; i < 2500; i++) begin
      rv = ($urandom_range(0, 9) == 0) ? NUM_SRC'($urandom_range(1, 127)) : '0;
      rp = ($urandom_range(0, 7) == 0) ? RH : 16'($urandom_range(1, 65535));
      cycle(rv, rp, 1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 199) == 0));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
